// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the PWM/GPIO bank: register map, CTRL bit layout and reset values.
package pwm_bank_pkg;

    localparam int unsigned AddrCtrl     = 0;
    localparam int unsigned AddrPrescale = 1;
    localparam int unsigned AddrPeriod   = 2;
    localparam int unsigned AddrGpio     = 3;
    localparam int unsigned AddrDutyBase = 4;

    localparam int unsigned CtrlEnBit     = 0;
    localparam int unsigned CtrlCenterBit = 1;

    localparam logic CtrlEnRst     = 1'b0;
    localparam logic CtrlCenterRst = 1'b0;

endpackage

// File: rtl/pwm_bank_timebase.sv
// Prescaler and period counter shared by all PWM channels; flags the period boundary.
// With PWMB_CENTER_ALIGN_EN defined, center mode counts up to the period and back down.
module pwm_bank_timebase
    import pwm_bank_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned PSCW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            center,
    input  logic [PSCW-1:0] prescale,
    input  logic [DW-1:0]   period,
    output logic [DW-1:0]   cnt,
    output logic            boundary
);

    logic [PSCW-1:0] psc_cnt_q, psc_cnt_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            tick;

    // >= keeps the prescaler from running the long way round after PRESCALE shrinks
    assign tick     = en && (psc_cnt_q >= prescale);
    assign boundary = tick && (cnt_d == '0);
    assign cnt      = cnt_q;

`ifdef PWMB_CENTER_ALIGN_EN
    logic dir_up_q, dir_up_d;

    always_comb begin
        psc_cnt_d = psc_cnt_q + 1'b1;
        cnt_d     = cnt_q;
        dir_up_d  = dir_up_q;
        if (!en) begin
            psc_cnt_d = '0;
            cnt_d     = '0;
            dir_up_d  = 1'b1;
        end else if (tick) begin
            psc_cnt_d = '0;
            if (!center) begin
                dir_up_d = 1'b1;
                cnt_d    = (cnt_q >= period) ? '0 : cnt_q + 1'b1;
            end else if (dir_up_q && (cnt_q < period)) begin
                cnt_d = cnt_q + 1'b1;
            end else if (cnt_q != '0) begin
                // Turning at the top or descending; resume counting up once 0 is reached.
                cnt_d    = cnt_q - 1'b1;
                dir_up_d = (cnt_q == DW'(1));
            end else begin
                dir_up_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
        end
    end
`else
    logic unused_center;
    assign unused_center = center;

    always_comb begin
        psc_cnt_d = psc_cnt_q + 1'b1;
        cnt_d     = cnt_q;
        if (!en) begin
            psc_cnt_d = '0;
            cnt_d     = '0;
        end else if (tick) begin
            psc_cnt_d = '0;
            cnt_d     = (cnt_q >= period) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/pwm_gpio_bank.sv
// NCH-channel register-mapped PWM bank with double-buffered duty/period and a GPIO latch.
// Define PWMB_CENTER_ALIGN_EN to enable the CTRL.CENTER center-aligned counting mode.
module pwm_gpio_bank
    import pwm_bank_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 4,
    parameter int unsigned PSCW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_req,
    input  logic            bus_we,
    input  logic [AW-1:0]   bus_addr,
    input  logic [DW-1:0]   bus_wdata,
    output logic [DW-1:0]   bus_rdata,
    output logic            bus_rvalid,
    output logic            bus_err,
    output logic [DW-1:0]   gpio_out,
    output logic [NCH-1:0]  pwm_out,
    output logic            period_stb
);

    localparam int unsigned NumRegs = AddrDutyBase + NCH;

    logic [31:0]            addr;
    logic                   mapped, load_sh, boundary, center_mode;
    logic [DW-1:0]          cnt;

    logic                   en_q, en_d;
    logic [PSCW-1:0]        prescale_q, prescale_d;
    logic [DW-1:0]          period_q, period_d, gpio_q, gpio_d;
    logic [NCH-1:0][DW-1:0] duty_q, duty_d, duty_sh_q, duty_sh_d;
    logic [DW-1:0]          period_sh_q, period_sh_d;
    logic [NCH-1:0]         pwm_q, pwm_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d, err_q, err_d;

    assign addr   = 32'(bus_addr);
    assign mapped = addr < NumRegs;

`ifdef PWMB_CENTER_ALIGN_EN
    logic center_q, center_d, center_sh_q, center_sh_d;

    assign center_sh_d = load_sh ? center_q : center_sh_q;
    assign center_mode = center_sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            center_q    <= CtrlCenterRst;
            center_sh_q <= CtrlCenterRst;
        end else begin
            center_q    <= center_d;
            center_sh_q <= center_sh_d;
        end
    end
`else
    assign center_mode = 1'b0;
`endif

    always_comb begin
        en_d       = en_q;
        prescale_d = prescale_q;
        period_d   = period_q;
        gpio_d     = gpio_q;
        duty_d     = duty_q;
`ifdef PWMB_CENTER_ALIGN_EN
        center_d   = center_q;
`endif
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        if (bus_req) begin
            err_d = ~mapped;
            if (bus_we) begin
                if (addr == AddrCtrl) begin
                    en_d = bus_wdata[CtrlEnBit];
`ifdef PWMB_CENTER_ALIGN_EN
                    center_d = bus_wdata[CtrlCenterBit];
`endif
                end
                if (addr == AddrPrescale) prescale_d = PSCW'(bus_wdata);
                if (addr == AddrPeriod)   period_d   = bus_wdata;
                if (addr == AddrGpio)     gpio_d     = bus_wdata;
                for (int unsigned ch = 0; ch < NCH; ch++) begin
                    if (addr == AddrDutyBase + ch) duty_d[ch] = bus_wdata;
                end
            end else begin
                rvalid_d = 1'b1;
                rdata_d  = '0;
                if (addr == AddrCtrl) begin
                    rdata_d[CtrlEnBit] = en_q;
`ifdef PWMB_CENTER_ALIGN_EN
                    rdata_d[CtrlCenterBit] = center_q;
`endif
                end
                if (addr == AddrPrescale) rdata_d = DW'(prescale_q);
                if (addr == AddrPeriod)   rdata_d = period_q;
                if (addr == AddrGpio)     rdata_d = gpio_q;
                for (int unsigned ch = 0; ch < NCH; ch++) begin
                    if (addr == AddrDutyBase + ch) rdata_d = duty_q[ch];
                end
            end
        end
    end

    // Shadows track the registers while disabled and otherwise only at a period boundary,
    // so a mid-period write never changes the waveform already in progress.
    assign load_sh = ~en_q | boundary;

    always_comb begin
        period_sh_d = load_sh ? period_q : period_sh_q;
        duty_sh_d   = load_sh ? duty_q : duty_sh_q;
        pwm_d       = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            pwm_d[ch] = en_q & (cnt < duty_sh_q[ch]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= CtrlEnRst;
            prescale_q  <= '0;
            period_q    <= '1;
            gpio_q      <= '0;
            duty_q      <= '0;
            period_sh_q <= '1;
            duty_sh_q   <= '0;
            pwm_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            en_q        <= en_d;
            prescale_q  <= prescale_d;
            period_q    <= period_d;
            gpio_q      <= gpio_d;
            duty_q      <= duty_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            pwm_q       <= pwm_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
        end
    end

    pwm_bank_timebase #(
        .DW   (DW),
        .PSCW (PSCW)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .en       (en_q),
        .center   (center_mode),
        .prescale (prescale_q),
        .period   (period_sh_q),
        .cnt      (cnt),
        .boundary (boundary)
    );

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign bus_err    = err_q;
    assign gpio_out   = gpio_q;
    assign pwm_out    = pwm_q;
    assign period_stb = boundary;

endmodule
